// File: rtl/da_shift_accumulator.sv
// Bit-serial shift-accumulate stage fed by the distributed-arithmetic LUT.
// One signed LUT partial sum arrives per activation bit-plane, LSB first. Each beat is
// sign-corrected by the tap-0 activation bit, weighted by 2^t and accumulated, with the
// MSB plane subtracted (two's-complement). One dot product per pixel leaves on a
// valid/ready handshake.
//
// Optional feature macro: DA_OFFSET_CORR_EN
//   defined   : result = acc - sext(offset), offset sampled on the t == 0 beat
//   undefined : offset port ignored, result is the raw shift-accumulated sum

module da_shift_accumulator #(
  parameter int DATA_WIDTH_A = 16,
  parameter int DATA_WIDTH_B = 16,
  parameter int K            = 9,
  parameter int LUT_WIDTH    = DATA_WIDTH_B + $clog2(K),
  localparam int ACC_WIDTH   = LUT_WIDTH + 1 + DATA_WIDTH_A
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [LUT_WIDTH:0]   lut_out,
  input  logic                        a0,
  input  logic [7:0]                  t,
  input  logic signed [LUT_WIDTH:0]   offset,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [ACC_WIDTH-1:0] acc_out,
  output logic                        seq_err
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  localparam logic [7:0] LastT = 8'(DATA_WIDTH_A - 1);

  state_e                      state_q, state_d;
  logic [7:0]                  exp_t_q, exp_t_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] acc_out_q, acc_out_d;
  logic                        out_valid_q, out_valid_d;
  logic                        seq_err_q, seq_err_d;

  logic                        accept;
  logic                        is_first;
  logic                        is_last;
  logic signed [ACC_WIDTH-1:0] lut_ext;
  logic signed [ACC_WIDTH-1:0] s_ext;
  logic signed [ACC_WIDTH-1:0] term;
  logic signed [ACC_WIDTH-1:0] signed_term;
  logic signed [ACC_WIDTH-1:0] corr;
  logic                        load_start;
  logic                        do_finish;
  logic signed [ACC_WIDTH-1:0] fin_val;

  // Handshake: a pending result blocks new beats unless it drains this cycle.
  assign in_ready  = !out_valid_q || out_ready;
  assign accept    = in_valid && in_ready;

  assign out_valid = out_valid_q;
  assign acc_out   = acc_out_q;
  assign seq_err   = seq_err_q;

  // Per-beat term: tap-0 sign fix, then binary weight. Negation happens after sign
  // extension so the most negative LUT value cannot overflow.
  always_comb begin
    lut_ext     = ACC_WIDTH'(lut_out);
    s_ext       = a0 ? lut_ext : -lut_ext;
    term        = s_ext <<< t;
    is_first    = (t == 8'd0);
    is_last     = (t == LastT);
    signed_term = is_last ? -term : term;
  end

`ifdef DA_OFFSET_CORR_EN
  logic signed [ACC_WIDTH-1:0] offset_q, offset_d;

  // Offset is captured on the first plane; when the first plane is also the last
  // (single-bit activations) the live port value is used directly.
  always_comb begin
    offset_d = offset_q;
    if (load_start) begin
      offset_d = ACC_WIDTH'(offset);
    end
    corr = is_first ? ACC_WIDTH'(offset) : offset_q;
  end

  // Offset register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      offset_q <= '0;
    end else begin
      offset_q <= offset_d;
    end
  end
`else
  logic unused_offset;
  assign unused_offset = ^offset;
  assign corr          = '0;
`endif

  // Next-state logic: sequence checking, accumulation and result capture.
  always_comb begin
    state_d     = state_q;
    exp_t_d     = exp_t_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    out_valid_d = out_valid_q;
    seq_err_d   = 1'b0;
    load_start  = 1'b0;
    do_finish   = 1'b0;
    fin_val     = acc_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_first) begin
            load_start = 1'b1;
          end else begin
            seq_err_d = 1'b1;
          end
        end
      end

      StAccum: begin
        if (accept) begin
          if (t == exp_t_q) begin
            if (is_last) begin
              do_finish = 1'b1;
              fin_val   = acc_q + signed_term;
            end else begin
              acc_d   = acc_q + signed_term;
              exp_t_d = exp_t_q + 8'd1;
            end
          end else begin
            // Out-of-order plane: drop the partial, but a fresh t == 0 restarts at once.
            seq_err_d = 1'b1;
            if (is_first) begin
              load_start = 1'b1;
            end else begin
              state_d = StIdle;
              exp_t_d = 8'd0;
              acc_d   = '0;
            end
          end
        end
      end

      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
          exp_t_d = 8'd0;
          if (accept) begin
            if (is_first) begin
              load_start = 1'b1;
            end else begin
              seq_err_d = 1'b1;
            end
          end
        end
      end

      default: begin
        state_d = StIdle;
        exp_t_d = 8'd0;
      end
    endcase

    if (load_start) begin
      if (is_last) begin
        // Single-plane activations: the only beat is the MSB.
        do_finish = 1'b1;
        fin_val   = signed_term;
      end else begin
        acc_d   = signed_term;
        exp_t_d = 8'd1;
        state_d = StAccum;
      end
    end

    if (do_finish) begin
      acc_out_d   = fin_val - corr;
      out_valid_d = 1'b1;
      state_d     = StDone;
      exp_t_d     = 8'd0;
      acc_d       = '0;
    end
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      exp_t_q     <= 8'd0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      out_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      exp_t_q     <= exp_t_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      out_valid_q <= out_valid_d;
      seq_err_q   <= seq_err_d;
    end
  end

endmodule

// File: tb/tb_da_shift_accumulator.sv
// Self-checking bench for da_shift_accumulator with 4-bit activations.
module tb_da_shift_accumulator;

  localparam int N      = 4;
  localparam int WB     = 16;
  localparam int KT     = 9;
  localparam int LUT_W  = WB + $clog2(KT);
  localparam int ACC_W  = LUT_W + 1 + N;
`ifdef DA_OFFSET_CORR_EN
  localparam bit OffEn = 1'b1;
`else
  localparam bit OffEn = 1'b0;
`endif

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [LUT_W:0]   lut_out;
  logic                    a0;
  logic [7:0]              t;
  logic signed [LUT_W:0]   offset;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] acc_out;
  logic                    seq_err;

  da_shift_accumulator #(
    .DATA_WIDTH_A(N),
    .DATA_WIDTH_B(WB),
    .K           (KT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .lut_out  (lut_out),
    .a0       (a0),
    .t        (t),
    .offset   (offset),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out  (acc_out),
    .seq_err  (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int lut, input logic ab, input int tt, input int off);
    in_valid = 1'b1;
    lut_out  = lut[LUT_W:0];
    a0       = ab;
    t        = 8'(tt);
    offset   = off[LUT_W:0];
  endtask

  // Directed vectors: one full 4-plane run each, a0 per plane in a0m[t].
  typedef struct {
    int         lut;
    logic [3:0] a0m;
    int         off;
    int         raw;
  } vec_t;

  vec_t vecs[5];

  function automatic int vexp(input vec_t v);
    return OffEn ? v.raw - v.off : v.raw;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    for (int b = 0; b < N; b++) begin
      drive_beat(v.lut, v.a0m[b], b, v.off);
      if (b == N - 1) check({tag, "_early_valid"}, out_valid, 0);
      tick();
    end
    in_valid = 1'b0;
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_acc"}, acc_out, vexp(v));
    tick();
    check({tag, "_drained"}, out_valid, 0);
  endtask

  // Reference model: beats collected so far; the expected plane index is simply how
  // many have been collected.
  typedef struct {
    longint lut;
    bit     a0;
    longint off;
  } beat_t;

  beat_t  m_beats[$];
  bit     m_out_valid;
  longint m_acc_out;
  bit     m_seq;

  function automatic longint model_result();
    longint r = 0;
    for (int i = 0; i < N; i++) begin
      longint s = m_beats[i].a0 ? m_beats[i].lut : -m_beats[i].lut;
      longint w = s * (longint'(1) << i);
      if (i == N - 1) r -= w;
      else r += w;
    end
    if (OffEn) r -= m_beats[0].off;
    return r;
  endfunction

  initial begin
    vecs[0] = '{lut: 10, a0m: 4'b1111, off: 5,   raw: -10};
    vecs[1] = '{lut: 10, a0m: 4'b1110, off: 5,   raw: -30};
    vecs[2] = '{lut: -7, a0m: 4'b1111, off: 0,   raw: 7};
    vecs[3] = '{lut: 1,  a0m: 4'b0111, off: -2,  raw: 15};
    vecs[4] = '{lut: -3, a0m: 4'b1010, off: 100, raw: 33};

    rst       = 1'b1;
    in_valid  = 1'b0;
    lut_out   = '0;
    a0        = 1'b0;
    t         = 8'd0;
    offset    = '0;
    out_ready = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_acc_out", acc_out, 0);
    check("rst_seq_err", seq_err, 0);
    check("rst_in_ready", in_ready, 1);
    tick();
    rst = 1'b0;
    tick();

    // Table-driven full runs with out_ready held high.
    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held for 3 cycles, then drains while a new run starts.
    out_ready = 1'b0;
    for (int b = 0; b < N; b++) begin
      drive_beat(10, 1'b1, b, 5);
      tick();
    end
    in_valid = 1'b0;
    check("bp_valid", out_valid, 1);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("bp_in_ready", in_ready, 0);
      check("bp_hold_acc", acc_out, vexp(vecs[0]));
      check("bp_hold_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    drive_beat(10, 1'b1, 0, 5);
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    check("bp_drained", out_valid, 0);
    for (int b = 1; b < N; b++) begin
      drive_beat(10, 1'b1, b, 5);
      tick();
    end
    in_valid = 1'b0;
    check("bp_next_valid", out_valid, 1);
    check("bp_next_acc", acc_out, vexp(vecs[0]));
    tick();

    // Skipped plane: t=0,1,3 must flag and produce nothing.
    drive_beat(10, 1'b1, 0, 5); tick();
    drive_beat(10, 1'b1, 1, 5); tick();
    drive_beat(10, 1'b1, 3, 5); tick();
    in_valid = 1'b0;
    check("skip_seq_err", seq_err, 1);
    check("skip_no_valid", out_valid, 0);
    tick();
    check("skip_seq_pulse", seq_err, 0);
    check("skip_no_valid2", out_valid, 0);
    // Non-zero plane while idle is dropped with an error.
    drive_beat(10, 1'b1, 2, 5); tick();
    in_valid = 1'b0;
    check("idle_seq_err", seq_err, 1);
    tick();
    check("idle_seq_pulse", seq_err, 0);
    run_vec(vecs[2], "after_skip");

    // Restart mid-run: a t=0 beat discards the partial and begins a new one.
    drive_beat(10, 1'b1, 0, 5); tick();
    drive_beat(10, 1'b1, 1, 5); tick();
    drive_beat(-7, 1'b1, 0, 0); tick();
    check("restart_seq_err", seq_err, 1);
    for (int b = 1; b < N; b++) begin
      drive_beat(-7, 1'b1, b, 0);
      tick();
    end
    in_valid = 1'b0;
    check("restart_valid", out_valid, 1);
    check("restart_acc", acc_out, 7);
    tick();

    // Asynchronous reset mid-accumulation.
    drive_beat(10, 1'b1, 0, 5); tick();
    drive_beat(10, 1'b1, 1, 5); tick();
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_acc", acc_out, 0);
    check("async_rst_ready", in_ready, 1);
    rst = 1'b0;
    tick();
    run_vec(vecs[2], "after_rst");

    // Randomized traffic against the reference model.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_beats.delete();
    m_out_valid = 1'b0;
    m_acc_out   = 0;
    m_seq       = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      int    lut_i;
      int    off_i;
      int    tt;
      bit    ab;
      bit    iv;
      bit    m_ready;
      bit    acc_beat;
      beat_t nb;
      lut_i = int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20);
      off_i = int'($urandom_range(0, (1 << 21) - 1)) - (1 << 20);
      ab    = 1'($urandom_range(0, 1));
      iv    = ($urandom_range(0, 3) != 0);
      tt    = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : m_beats.size();
      drive_beat(lut_i, ab, tt, off_i);
      in_valid  = iv;
      out_ready = ($urandom_range(0, 2) != 0);
      m_ready   = !m_out_valid || out_ready;
      #1;
      check("rnd_in_ready", in_ready, m_ready);
      @(posedge clk);
      acc_beat = iv && m_ready;
      if (m_out_valid && out_ready) m_out_valid = 1'b0;
      m_seq = 1'b0;
      if (acc_beat) begin
        nb = '{lut: longint'(lut_i), a0: ab, off: longint'(off_i)};
        if (tt == m_beats.size()) begin
          m_beats.push_back(nb);
        end else begin
          m_seq = 1'b1;
          m_beats.delete();
          if (tt == 0) m_beats.push_back(nb);
        end
        if (m_beats.size() == N) begin
          m_acc_out   = model_result();
          m_out_valid = 1'b1;
          m_beats.delete();
        end
      end
      #1;
      check("rnd_out_valid", out_valid, m_out_valid);
      check("rnd_acc_out", acc_out, m_acc_out);
      check("rnd_seq_err", seq_err, m_seq);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
